// File: rtl/pwm_frame_sequencer_if.sv
// ============================================================================
// Module   : pwm_frame_sequencer_if
// Purpose  : Set-point mailbox handshake between a duty-value producer and
//            the PWM frame sequencer (valid/ready plus a busy indicator).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pwm_frame_sequencer_if #(
  parameter int PWM_RES = 10
);
  logic               set_valid;
  logic [PWM_RES-1:0] set_value;
  logic               set_ready;
  logic               busy;

  // Producer side: offers set-points, observes mailbox state
  modport master (
    output set_valid,
    output set_value,
    input  set_ready,
    input  busy
  );

  // Sequencer side: accepts set-points, reports mailbox state
  modport slave (
    input  set_valid,
    input  set_value,
    output set_ready,
    output busy
  );
endinterface

`default_nettype wire

// File: rtl/pwm_frame_sequencer.sv
// ============================================================================
// Module   : pwm_frame_sequencer
// Purpose  : Frame timing front end for the PWM generator. Accepts duty
//            set-points through a depth-1 mailbox, times frames of
//            SLOTS = 2**PWM_RES-1 LSB slots, pulses sync_signal for one clock
//            at every frame start, and changes pwm_value / t_lsb_out only on
//            frame boundaries.
// Options  : define PWM_SLEW_EN to limit each boundary's duty change to STEP
//            (pending stays set until the target is reached).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_frame_sequencer #(
  parameter int                 PWM_RES = 10,
  parameter logic [PWM_RES-1:0] STEP    = PWM_RES'(8)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [11:0]          t_lsb,
  pwm_frame_sequencer_if.slave set,
  output logic [PWM_RES-1:0]   pwm_value,
  output logic                 sync_signal,
  output logic [11:0]          t_lsb_out
);

  // Index of the last LSB slot in a frame (SLOTS - 1)
  localparam logic [PWM_RES-1:0] SLOT_LAST = PWM_RES'((2 ** PWM_RES) - 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t             state_q;
  logic [11:0]        cyc_q;
  logic [PWM_RES-1:0] slot_q;
  logic [11:0]        t_lsb_q;
  logic [PWM_RES-1:0] pwm_q;
  logic               sync_q;
  logic [PWM_RES-1:0] target_q;
  logic               pending_q;

  logic               frame_end;
  logic               boundary;
  logic               accept;
  logic [PWM_RES-1:0] pwm_next_d;

  // Last clock of a frame: final cycle of the final slot
  assign frame_end = (state_q != IDLE) && (cyc_q == t_lsb_q) && (slot_q == SLOT_LAST);
  // A boundary edge is the one that enters START (from IDLE or a frame wrap)
  assign boundary  = enable && ((state_q == IDLE) || frame_end);
  assign accept    = set.set_valid && !pending_q;

`ifdef PWM_SLEW_EN
  logic [PWM_RES:0] cur_w;
  logic [PWM_RES:0] tgt_w;
  logic [PWM_RES:0] step_w;
  logic [PWM_RES:0] up_w;
  logic [PWM_RES:0] dn_w;

  // One extra bit keeps the step arithmetic from wrapping
  assign cur_w  = {1'b0, pwm_q};
  assign tgt_w  = {1'b0, target_q};
  assign step_w = {1'b0, STEP};
  assign up_w   = cur_w + step_w;
  assign dn_w   = cur_w - step_w;

  // Move toward the target by at most STEP, clamping at the target
  always_comb begin
    pwm_next_d = pwm_q;
    if (cur_w < tgt_w) begin
      pwm_next_d = (up_w >= tgt_w) ? target_q : up_w[PWM_RES-1:0];
    end else if (cur_w > tgt_w) begin
      pwm_next_d = ((cur_w - tgt_w) <= step_w) ? target_q : dn_w[PWM_RES-1:0];
    end
  end
`else
  // STEP only matters for slew limiting; fold it into a sink signal
  logic unused_step;
  assign unused_step = ^STEP;

  // Without slew limiting the whole change lands on one boundary
  always_comb begin
    pwm_next_d = target_q;
  end
`endif

  // Frame FSM: counters, registered sync pulse and boundary-latched outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      slot_q  <= '0;
      t_lsb_q <= '0;
      pwm_q   <= '0;
      sync_q  <= 1'b0;
    end else if (!enable) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      slot_q  <= '0;
      sync_q  <= 1'b0;
    end else if (boundary) begin
      // START is slot 0 / cycle 0 of the new frame
      state_q <= START;
      sync_q  <= 1'b1;
      cyc_q   <= '0;
      slot_q  <= '0;
      t_lsb_q <= t_lsb;
      if (pending_q) begin
        pwm_q <= pwm_next_d;
      end
    end else begin
      state_q <= RUN;
      sync_q  <= 1'b0;
      if (cyc_q == t_lsb_q) begin
        cyc_q  <= '0;
        slot_q <= slot_q + 1'b1;
      end else begin
        cyc_q  <= cyc_q + 12'd1;
      end
    end
  end

  // Depth-1 mailbox: fill on accept, drain once the applied duty hits target
  always_ff @(posedge clk) begin
    if (reset) begin
      target_q  <= '0;
      pending_q <= 1'b0;
    end else if (accept) begin
      target_q  <= set.set_value;
      pending_q <= 1'b1;
    end else if (boundary && pending_q && (pwm_next_d == target_q)) begin
      pending_q <= 1'b0;
    end
  end

  assign set.set_ready = !pending_q;
  assign set.busy      = pending_q;
  assign pwm_value     = pwm_q;
  assign sync_signal   = sync_q;
  assign t_lsb_out     = t_lsb_q;

endmodule

`default_nettype wire
